// File: rtl/fetch_queue.sv
// Instruction buffer between fetch and decode: circular buffer of {pc, instr}
// with valid/ready handshakes on both sides and a flush on taken branches.
module fetch_queue #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned IW    = 32,
  parameter int unsigned AW    = 64
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         PCSrc_F,
  input  logic [AW-1:0]                imem_addr_F,
  input  logic [IW-1:0]                imem_data_F,
  input  logic                         valid_F,
  output logic                         ready_F,
  output logic [IW-1:0]                instr_D,
  output logic [AW-1:0]                pc_D,
  output logic                         valid_D,
  input  logic                         ready_D,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  logic [IW-1:0] instr_mem_q [DEPTH];
  logic [AW-1:0] pc_mem_q    [DEPTH];

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  logic push, pop;

  // Handshake outputs depend only on registered state and reset, never on ready_D.
  assign ready_F = !reset && (count_q < CW'(DEPTH));
  assign valid_D = !reset && (count_q != '0);
  assign instr_D = valid_D ? instr_mem_q[rd_ptr_q] : '0;
  assign pc_D    = valid_D ? pc_mem_q[rd_ptr_q]    : '0;
  assign count   = count_q;

  assign push = valid_F && ready_F && !PCSrc_F;
  assign pop  = valid_D && ready_D && !PCSrc_F;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (PCSrc_F) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      if (push && !pop)      count_d = count_q + CW'(1);
      else if (pop && !push) count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset; push is already suppressed by reset and flush.
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem_q[wr_ptr_q] <= imem_data_F;
      pc_mem_q[wr_ptr_q]    <= imem_addr_F;
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Self-checking bench for fetch_queue: directed test-plan phases plus random
// traffic, all compared each cycle against a queue-based reference model.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned IW    = 32;
  localparam int unsigned AW    = 64;

  logic          clk = 1'b0;
  logic          reset;
  logic          PCSrc_F;
  logic [AW-1:0] imem_addr_F;
  logic [IW-1:0] imem_data_F;
  logic          valid_F;
  logic          ready_F;
  logic [IW-1:0] instr_D;
  logic [AW-1:0] pc_D;
  logic          valid_D;
  logic          ready_D;
  logic [$clog2(DEPTH+1)-1:0] count;

  fetch_queue #(.DEPTH(DEPTH), .IW(IW), .AW(AW)) dut (
    .clk         (clk),
    .reset       (reset),
    .PCSrc_F     (PCSrc_F),
    .imem_addr_F (imem_addr_F),
    .imem_data_F (imem_data_F),
    .valid_F     (valid_F),
    .ready_F     (ready_F),
    .instr_D     (instr_D),
    .pc_D        (pc_D),
    .valid_D     (valid_D),
    .ready_D     (ready_D),
    .count       (count)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  // Reference model: program-order list of buffered {pc, instr} entries.
  logic [AW+IW-1:0] model_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic check_outputs();
    logic          exp_valid, exp_ready;
    logic [AW-1:0] exp_pc;
    logic [IW-1:0] exp_instr;
    exp_valid = !reset && (model_q.size() != 0);
    exp_ready = !reset && (model_q.size() < DEPTH);
    exp_pc    = exp_valid ? model_q[0][AW+IW-1:IW] : '0;
    exp_instr = exp_valid ? model_q[0][IW-1:0]     : '0;
    check("count",   64'(count),   64'(model_q.size()));
    check("valid_D", 64'(valid_D), 64'(exp_valid));
    check("ready_F", 64'(ready_F), 64'(exp_ready));
    check("pc_D",    64'(pc_D),    64'(exp_pc));
    check("instr_D", 64'(instr_D), 64'(exp_instr));
  endtask

  // Drive one cycle of inputs, advance the model on the edge, check at negedge.
  task automatic cycle(input logic r, input logic f, input logic vf,
                       input logic [AW-1:0] pc, input logic [IW-1:0] ins,
                       input logic rd);
    logic m_ready, m_valid;
    reset = r; PCSrc_F = f; valid_F = vf;
    imem_addr_F = pc; imem_data_F = ins; ready_D = rd;
    m_ready = !r && (model_q.size() < DEPTH);
    m_valid = !r && (model_q.size() != 0);
    @(posedge clk);
    if (r || f) model_q.delete();
    else begin
      if (m_valid && rd) void'(model_q.pop_front());
      if (vf && m_ready) model_q.push_back({pc, ins});
    end
    @(negedge clk);
    check_outputs();
  endtask

  logic [IW-1:0] prog [4];

  initial begin
    prog[0] = 32'h8B020020; prog[1] = 32'hF8400041;
    prog[2] = 32'hCB030082; prog[3] = 32'hB4000060;
    reset = 1'b1; PCSrc_F = 1'b0; valid_F = 1'b0; ready_D = 1'b0;
    imem_addr_F = '0; imem_data_F = '0;
    @(negedge clk);

    for (int i = 0; i < 5; i++) cycle(1, 0, 0, '0, '0, 0);
    cycle(0, 0, 0, '0, '0, 0);
    check("ready_after_reset", 64'(ready_F), 64'd1);

    // Fill with decode stalled, then attempt a fifth push.
    for (int i = 0; i < 4; i++) cycle(0, 0, 1, 64'(4*i), prog[i], 0);
    check("fill_count", 64'(count), 64'd4);
    check("fill_head_instr", 64'(instr_D), 64'h8B020020);
    cycle(0, 0, 1, 64'd16, 32'h11111111, 0);
    check("full_reject", 64'(count), 64'd4);

    // Drain in order.
    for (int i = 0; i < 4; i++) begin
      check("drain_pc", 64'(pc_D), 64'(4*i));
      cycle(0, 0, 0, '0, '0, 1);
    end
    check("drained_valid", 64'(valid_D), 64'd0);

    // Steady stream across pointer wrap.
    for (int i = 0; i < 10; i++) begin
      cycle(0, 0, 1, 64'(4*i), 32'(32'hA000_0000 + i), 1);
      check("stream_count", 64'(count), 64'd1);
      check("stream_pc", 64'(pc_D), 64'(4*i));
    end
    cycle(0, 0, 0, '0, '0, 1);

    // Flush with a concurrent push.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 64'(16 + 4*i), 32'(i), 0);
    check("preflush_count", 64'(count), 64'd3);
    cycle(0, 1, 1, 64'd28, 32'hDEAD0028, 0);
    check("flush_count", 64'(count), 64'd0);
    check("flush_valid", 64'(valid_D), 64'd0);
    cycle(0, 0, 1, 64'd16, 32'hBEEF0016, 0);
    check("postflush_pc", 64'(pc_D), 64'd16);
    check("postflush_count", 64'(count), 64'd1);

    // Full plus pop: pop frees a slot, push only lands next cycle.
    for (int i = 0; i < 3; i++) cycle(0, 0, 1, 64'(20 + 4*i), 32'(i), 0);
    check("full_count", 64'(count), 64'd4);
    cycle(0, 0, 1, 64'd40, 32'h00000040, 1);
    check("full_pop_count", 64'(count), 64'd3);
    cycle(0, 0, 1, 64'd40, 32'h00000040, 1);
    check("push_pop_count", 64'(count), 64'd3);

    // Random traffic including occasional flush and reset.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(99) < 2), ($urandom_range(99) < 5),
            ($urandom_range(99) < 70),
            {$urandom, $urandom}, $urandom,
            ($urandom_range(99) < 55));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/fetch_queue.md
Name: fetch_queue

Overview:
Instruction buffer between the fetch stage and decode. Captures each fetched instruction word with the PC it was fetched from (the fetch stage's imem_addr_F). Presents them to decode in program order through a valid/ready handshake. Absorbs decode stalls and discards all buffered work on a taken branch (PCSrc_F), so decode never executes wrong-path instructions.

Parameters:
DEPTH, 4, number of entries; power of two, >= 2
IW, 32, instruction word width
AW, 64, PC width

Ports:
clk  in  1  clock, all state updates on the rising edge
reset  in  1  synchronous, active-high reset
PCSrc_F  in  1  flush: taken branch redirect, discard all entries
imem_addr_F  in  AW  PC of the incoming instruction
imem_data_F  in  IW  incoming instruction word
valid_F  in  1  incoming instruction is valid
ready_F  out  1  queue accepts an instruction this cycle
instr_D  out  IW  head instruction to decode
pc_D  out  AW  PC of head instruction
valid_D  out  1  head entry valid
ready_D  in  1  decode consumes head this cycle
count  out  $clog2(DEPTH+1)  number of occupied entries

Behaviour:
- Storage: circular buffer of DEPTH entries {pc, instr}. Read and write pointers are $clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0. count is a separate register.
- Reset, sampled on a rising edge while reset=1:
  - count=0, both pointers=0.
  - While reset is high: valid_D=0, ready_F=0, instr_D=0, pc_D=0.
  - Storage contents are don't-care.
- ready_F = !reset && (count < DEPTH). It depends only on registered state; there is no combinational path from ready_D.
- valid_D = (count != 0).
- instr_D and pc_D are driven from the head entry when valid_D=1, and are 0 when the queue is empty.
- push = valid_F && ready_F && !PCSrc_F. The entry is written at the write pointer on the edge, and the write pointer increments.
- pop = valid_D && ready_D && !PCSrc_F. The read pointer increments on the edge.
- count_next:
  - push and no pop: count+1
  - pop and no push: count-1
  - push and pop together: count unchanged
- Latency: an instruction pushed at edge N is visible on instr_D/pc_D after edge N. There is no same-cycle bypass from input to output.
- Full (count=DEPTH):
  - ready_F=0.
  - A pop that cycle frees one entry, but the push is not accepted until the next cycle.
  - valid_F held high is not lost; the fetch side holds its data.
- Empty (count=0): valid_D=0. ready_D is ignored.
- Simultaneous push and pop at 0<count<DEPTH: both occur and order is preserved.
- Flush, PCSrc_F=1 on an edge:
  - count=0 and both pointers=0.
  - Any concurrent push or pop is discarded.
  - valid_D=0 the following cycle.
- Priority: reset > flush > push/pop.
- Reset or flush asserted mid-stream: behaviour identical to the rules above. No partial entries survive.
- PC values are stored verbatim; no arithmetic is performed on them.
- Illegal: ready_D sampled while valid_D=0 has no effect.

Test Plan:
- Reset held 5 cycles, then released:
  - During reset: valid_D=0, ready_F=0, count=0, pc_D=0.
  - First cycle after release: ready_F=1, valid_D=0.
- Fill with ready_D=0:
  - Push PC 0,4,8,12 with instr 0x8B020020, 0xF8400041, 0xCB030082, 0xB4000060.
  - After the 4th push: count=4, ready_F=0.
  - Head shows pc_D=0, instr_D=0x8B020020.
  - A 5th valid_F is not accepted.
- Drain with ready_D=1, valid_F=0:
  - pc_D sequence is 0, 4, 8, 12 on consecutive cycles.
  - Then valid_D=0 and count=0.
- Steady stream:
  - Push PC 0..36 step 4 (10 entries) while ready_D=1.
  - count reaches 1 and stays at 1 during simultaneous push/pop.
  - pc_D observed in order 0..36, which exercises pointer wrap-around.
- Flush:
  - With count=3 (PC 16, 20, 24), assert PCSrc_F for one cycle together with valid_F (PC 28).
  - Next cycle: count=0, valid_D=0, PC 28 is discarded.
  - Push PC 16 afterwards: pc_D=16, count=1.
- Full plus pop:
  - At count=4, ready_D=1 and valid_F=1 (PC 40).
  - Count drops to 3 with no push that cycle.
  - Next cycle PC 40 is accepted: count stays 3 with push and pop.
